// File: rtl/pulse_divider.sv
// pulse_divider
// -------------
// Multi-channel clock-enable generator. Each channel divides clk by its own
// runtime-programmable divisor and drives either a one-cycle pulse (mode=0)
// or a square wave (mode=1) that is high for floor(div/2) cycles and is
// phase-aligned with the pulses. Reset divisors are 2, 4, 8, 16, ...
// (truncated to WIDTH bits, where 0 means the channel is disabled).
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-low reset
//   en         global count enable
//   clr        synchronous clear of counters/outputs; applies pending divisors
//   mode       0 = pulse, 1 = square wave
//   cfg_valid  divisor write request
//   cfg_ch     target channel of the write
//   cfg_div    new divisor value
//   cfg_ready  write can be accepted (1 for out-of-range channels)
//   out        per-channel registered output
module pulse_divider #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              mode,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_div,
    output logic              cfg_ready,
    output logic [NUM_CH-1:0] out
);

    logic [WIDTH-1:0]  cnt_q      [NUM_CH];
    logic [WIDTH-1:0]  cnt_d      [NUM_CH];
    logic [WIDTH-1:0]  div_q      [NUM_CH];
    logic [WIDTH-1:0]  div_d      [NUM_CH];
    logic [WIDTH-1:0]  pend_div_q [NUM_CH];
    logic [WIDTH-1:0]  pend_div_d [NUM_CH];
    logic [WIDTH-1:0]  cnt_inc    [NUM_CH];
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] pending_d;
    logic [NUM_CH-1:0] out_q;
    logic [NUM_CH-1:0] out_d;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] apply_div;
    logic              cfg_accept;

    // Ready is driven only by the selected channel's pending flag; channel
    // numbers with no matching channel fall through to 1 so those writes are
    // swallowed rather than stalling the requester forever.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pending_q[i];
            end
        end
        cfg_accept = cfg_valid & cfg_ready;
    end

    // Modulo-div counter increment. Comparing against div-1 (rather than
    // counting to div) keeps the counter within WIDTH bits for every div.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_inc[i] = (cnt_q[i] == div_q[i] - WIDTH'(1)) ? '0 : cnt_q[i] + WIDTH'(1);
            wrap[i]    = (cnt_inc[i] == '0);
        end
    end

    // Per-channel next state. A pending divisor only swaps in at a wrap, on a
    // disabled channel, or on clr, so a period is never cut short. A write
    // accepted on the same edge as a wrap lands in pend_div and waits for the
    // following wrap, because apply_div looks only at the registered flag.
    always_comb begin
        apply_div = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]      = cnt_q[i];
            div_d[i]      = div_q[i];
            pend_div_d[i] = pend_div_q[i];
            pending_d[i]  = pending_q[i];
            out_d[i]      = out_q[i];

            if (div_q[i] == '0 || clr) begin
                cnt_d[i]     = '0;
                out_d[i]     = 1'b0;
                apply_div[i] = pending_q[i];
            end else if (en) begin
                cnt_d[i]     = cnt_inc[i];
                out_d[i]     = mode ? (cnt_inc[i] < (div_q[i] >> 1)) : wrap[i];
                apply_div[i] = pending_q[i] & wrap[i];
            end else begin
                out_d[i] = mode & out_q[i];
            end

            if (apply_div[i]) begin
                div_d[i]     = pend_div_q[i];
                pending_d[i] = 1'b0;
            end else if (cfg_accept && cfg_ch == CH_W'(i)) begin
                pending_d[i]  = 1'b1;
                pend_div_d[i] = cfg_div;
            end
        end
    end

    // State registers. The reset divisor 1 << (i+1) naturally becomes 0 once
    // the shift reaches WIDTH, which disables the upper channels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]      <= '0;
                div_q[i]      <= WIDTH'(1) << (i + 1);
                pend_div_q[i] <= '0;
            end
            pending_q <= '0;
            out_q     <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]      <= cnt_d[i];
                div_q[i]      <= div_d[i];
                pend_div_q[i] <= pend_div_d[i];
            end
            pending_q <= pending_d;
            out_q     <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_pulse_divider.sv
// tb_pulse_divider
// ----------------
// Drives two pulse_divider instances from one shared stimulus stream:
//   u_dut_a : WIDTH=8, NUM_CH=4 (legacy divide-by-2/4/8/16 defaults)
//   u_dut_b : WIDTH=4, NUM_CH=6 (truncated defaults, channels 3..5 disabled,
//             out-of-range channel numbers 6 and 7)
// A behavioural model predicts out/cfg_ready after every edge; predictions
// are queued by the driver and popped by an independent monitor.
module tb_pulse_divider;

    typedef struct {
        logic [3:0] a_out;
        logic       a_rdy;
        logic [5:0] b_out;
        logic       b_rdy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       mode = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [2:0] cfg_ch = '0;
    logic [7:0] cfg_div = '0;
    logic       a_ready;
    logic       b_ready;
    logic [3:0] a_out;
    logic [5:0] b_out;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    // Model state: index 0 models u_dut_a, index 1 models u_dut_b.
    int m_cnt  [2][6];
    int m_div  [2][6];
    int m_pdiv [2][6];
    bit m_pend [2][6];
    bit m_out  [2][6];

    always #5 clk = ~clk;

    pulse_divider #(.WIDTH(8), .NUM_CH(4)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
        .cfg_valid(cfg_valid), .cfg_ch(cfg_ch[1:0]), .cfg_div(cfg_div),
        .cfg_ready(a_ready), .out(a_out)
    );

    pulse_divider #(.WIDTH(4), .NUM_CH(6)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
        .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_div(cfg_div[3:0]),
        .cfg_ready(b_ready), .out(b_out)
    );

    function automatic int nch(input int m);
        return (m == 0) ? 4 : 6;
    endfunction

    function automatic int wid(input int m);
        return (m == 0) ? 8 : 4;
    endfunction

    function automatic int chSel(input int m, input int ch);
        return (m == 0) ? (ch % 4) : (ch % 8);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 6; i++) begin
                m_cnt[m][i]  = 0;
                m_pend[m][i] = 1'b0;
                m_out[m][i]  = 1'b0;
                m_pdiv[m][i] = 0;
                m_div[m][i]  = (i + 1 < wid(m)) ? (1 << (i + 1)) : 0;
            end
        end
    endtask

    function automatic bit modelReady(input int m, input int ch);
        int c;
        c = chSel(m, ch);
        if (c >= nch(m)) return 1'b1;
        return !m_pend[m][c];
    endfunction

    function automatic int modelOut(input int m);
        int r;
        r = 0;
        for (int i = 0; i < nch(m); i++) begin
            if (m_out[m][i]) r |= (1 << i);
        end
        return r;
    endfunction

    // One clock edge of the reference: counting is plain modulo-div arithmetic.
    task automatic modelStep(input int m, input bit e, input bit c, input bit md,
                             input bit v, input int ch, input int dv);
        int  sel;
        int  d;
        int  nxt;
        bit  acc;
        bit  apply;
        sel = chSel(m, ch);
        d   = dv % (1 << wid(m));
        acc = v && modelReady(m, ch);
        for (int i = 0; i < nch(m); i++) begin
            apply = 1'b0;
            if (m_div[m][i] == 0 || c) begin
                m_cnt[m][i] = 0;
                m_out[m][i] = 1'b0;
                apply = m_pend[m][i];
            end else if (e) begin
                nxt = (m_cnt[m][i] + 1) % m_div[m][i];
                m_out[m][i] = md ? (nxt < m_div[m][i] / 2) : (nxt == 0);
                m_cnt[m][i] = nxt;
                apply = m_pend[m][i] && (nxt == 0);
            end else if (!md) begin
                m_out[m][i] = 1'b0;
            end
            if (apply) begin
                m_div[m][i]  = m_pdiv[m][i];
                m_pend[m][i] = 1'b0;
            end else if (acc && sel == i) begin
                m_pend[m][i] = 1'b1;
                m_pdiv[m][i] = d;
            end
        end
    endtask

    task automatic pushExpect(input int ch);
        exp_t e;
        e.a_out = 4'(modelOut(0));
        e.a_rdy = modelReady(0, ch);
        e.b_out = 6'(modelOut(1));
        e.b_rdy = modelReady(1, ch);
        sb_q.push_back(e);
    endtask

    // Called at negedge+1: drive inputs for the next rising edge, predict the
    // result, then wait until just after the following falling edge.
    task automatic applyStimulus(input bit e, input bit c, input bit md,
                                 input bit v, input int ch, input int dv);
        en        = e;
        clr       = c;
        mode      = md;
        cfg_valid = v;
        cfg_ch    = 3'(ch);
        cfg_div   = 8'(dv);
        modelStep(0, e, c, md, v, ch, dv);
        modelStep(1, e, c, md, v, ch, dv);
        pushExpect(ch);
        @(negedge clk);
        #1;
    endtask

    // Asserts reset between edges so the output clear must be asynchronous.
    task automatic doReset(input int n);
        rst       = 1'b0;
        en        = 1'b0;
        clr       = 1'b0;
        mode      = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        modelReset();
        #1;
        checkOutput("async_rst_a_out", int'(a_out), 0);
        checkOutput("async_rst_b_out", int'(b_out), 0);
        for (int k = 0; k < n; k++) begin
            pushExpect(0);
            @(negedge clk);
            #1;
        end
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checkOutput("sb_a_out",   int'(a_out),   int'(mon_e.a_out));
            checkOutput("sb_a_ready", int'(a_ready), int'(mon_e.a_rdy));
            checkOutput("sb_b_out",   int'(b_out),   int'(mon_e.b_out));
            checkOutput("sb_b_ready", int'(b_ready), int'(mon_e.b_rdy));
        end
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  first_a [4];
        int  count_a [4];
        int  first_b [6];
        int  count_b [6];
        int  mask_a;
        int  mask_b;
        bit  md;
        int  sel;
        int  dv;

        @(negedge clk);
        #1;
        doReset(2);

        // Legacy defaults: record the first pulse edge and pulse count.
        for (int i = 0; i < 4; i++) begin first_a[i] = 0; count_a[i] = 0; end
        for (int i = 0; i < 6; i++) begin first_b[i] = 0; count_b[i] = 0; end
        for (int k = 1; k <= 1000; k++) begin
            applyStimulus(1, 0, 0, 0, 0, 0);
            for (int i = 0; i < 4; i++) begin
                if (a_out[i]) begin
                    count_a[i]++;
                    if (first_a[i] == 0) first_a[i] = k;
                end
            end
            for (int i = 0; i < 6; i++) begin
                if (b_out[i]) begin
                    count_b[i]++;
                    if (first_b[i] == 0) first_b[i] = k;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("default_first_a%0d", i), first_a[i], 2 << i);
            checkOutput($sformatf("default_count_a%0d", i), count_a[i], 1000 / (2 << i));
        end
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("default_count_b%0d", i), count_b[i],
                        (i < 3) ? 1000 / (2 << i) : 0);
        end
        checkOutput("default_ready_a", int'(a_ready), 1);

        // Reprogram ch1 to 5 while cnt[1]=1; old pulse at E4, then E9, E14.
        applyStimulus(0, 1, 0, 0, 0, 0);
        mask_a = 0;
        mask_b = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 2)                applyStimulus(1, 0, 0, 1, 1, 5);
            else if (k == 3 || k == 4) applyStimulus(1, 0, 0, 1, 1, 9);
            else                       applyStimulus(1, 0, 0, 0, 1, 0);
            if (k == 2) checkOutput("reprog_ready_low", int'(a_ready), 0);
            if (k == 4) checkOutput("reprog_ready_back", int'(a_ready), 1);
            if (a_out[1]) mask_a |= (1 << k);
            if (b_out[1]) mask_b |= (1 << k);
        end
        checkOutput("reprog_pulses_a1", mask_a, (1 << 4) | (1 << 9) | (1 << 14));
        checkOutput("reprog_pulses_b1", mask_b, (1 << 4) | (1 << 9) | (1 << 14));

        // Pending ch2=3 applied by clr; first ch2 pulse after E3.
        applyStimulus(1, 0, 0, 1, 2, 3);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        checkOutput("clr_out_a", int'(a_out), 0);
        checkOutput("clr_out_b", int'(b_out), 0);
        mask_a = 0;
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1, 0, 0, 0, 0, 0);
            if (a_out[2]) mask_a |= (1 << k);
        end
        checkOutput("clr_pulses_a2", mask_a, (1 << 3) | (1 << 6));

        // Square wave with div=7 on ch0: high on edges where k mod 7 < 3.
        applyStimulus(0, 0, 1, 1, 0, 7);
        applyStimulus(0, 1, 1, 0, 0, 0);
        mask_a = 0;
        mask_b = 0;
        for (int k = 1; k <= 14; k++) begin
            applyStimulus(1, 0, 1, 0, 0, 0);
            if (a_out[0]) mask_a |= (1 << k);
            if (b_out[0]) mask_b |= (1 << k);
        end
        checkOutput("square7_a0", mask_a, (1 << 1) | (1 << 2) | (1 << 7) | (1 << 8) | (1 << 9) | (1 << 14));
        checkOutput("square7_b0", mask_b, (1 << 1) | (1 << 2) | (1 << 7) | (1 << 8) | (1 << 9) | (1 << 14));

        // Randomized traffic with one asynchronous reset in the middle.
        md = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (k == 1000) doReset(2);
            if ($urandom_range(49) == 0) md = ~md;
            sel = $urandom_range(3);
            if (sel == 0)      dv = $urandom_range(3);
            else if (sel == 3) dv = $urandom_range(255);
            else               dv = $urandom_range(9);
            applyStimulus($urandom_range(3) != 0, $urandom_range(63) == 0, md,
                          $urandom_range(2) == 0, $urandom_range(7), dv);
        end

        @(negedge clk);
        #1;
        checkOutput("sb_drain", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
